// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues imem word reads,
// buffers returned words and hands Instr/PC to decode with valid/ready.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   imem_req/addr          read request and word address to imem
//   imem_gnt               request accepted this cycle
//   imem_rvalid/rdata      in-order read response
//   Instr, PC, PCPlus4     FIFO head to decode (NOP when not valid)
//   instr_valid/ready      decode handshake
//   PCSrc, PCTarget        redirect request and target address

module instr_fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = ((CW > FW) ? CW : FW) + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_instr_d [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_d    [FIFO_DEPTH];

  logic            rsp_ok;
  logic            grant;
  logic            push;
  logic            pop;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] tgt_pc;

  // Responses with nothing outstanding are protocol errors and ignored.
  assign rsp_ok = imem_rvalid && (out_q != '0);

  // Slots already promised to in-flight, non-dropped responses.
  assign credit_used = SW'(cnt_q) + SW'(out_q) - SW'(drop_q);

  assign imem_req = !reset && !PCSrc
                 && (out_q < CW'(MAX_OUTSTANDING))
                 && (credit_used < SW'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;

  assign grant       = imem_req && imem_gnt;
  assign instr_valid = !reset && (cnt_q != '0);
  assign pop         = instr_valid && instr_ready && !PCSrc;
  assign push        = rsp_ok && (drop_q == '0) && !PCSrc;
  assign tgt_pc      = PCTarget & ~XLEN'(3);

  assign Instr = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP;

  always_comb begin
    PC = resp_pc_q;
    if (reset) begin
      PC = RESET_PC;
    end else if (instr_valid) begin
      PC = fifo_pc_q[rd_ptr_q];
    end
  end

  assign PCPlus4 = PC + XLEN'(4);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    out_d        = out_q;
    drop_d       = drop_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      out_d      = out_d + CW'(1);
    end

    if (rsp_ok) begin
      out_d = out_d - CW'(1);
      if (drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end
    end

    if (push) begin
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      fifo_pc_d[wr_ptr_q]    = resp_pc_q;
      wr_ptr_d  = wr_ptr_q + PW'(1);
      resp_pc_d = resp_pc_q + XLEN'(4);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + FW'(1);
      2'b01:   cnt_d = cnt_q - FW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Redirect: every request still in flight after this cycle is stale.
    if (PCSrc) begin
      fetch_pc_d = tgt_pc;
      resp_pc_d  = tgt_pc;
      drop_d     = out_d;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset; cnt_q gates its visibility.
  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle in-order memory
// responder and an expected-PC scoreboard on every decode pop.

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pend[$];
  bit          mem_en;
  bit          stray;
  logic [31:0] exp_pc;
  int          nchk;
  int          nerr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, model memory, score pops.
  task automatic cyc(input bit rst, input bit src,
                     input logic [31:0] tgt,
                     input bit rdy, input bit g);
    @(negedge clk);
    reset       = rst;
    PCSrc       = src;
    PCTarget    = tgt;
    instr_ready = rdy;
    imem_gnt    = g;
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      stray       = 1'b0;
    end else if (mem_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    if (imem_req && imem_gnt) pend.push_back(imem_addr);
    if (instr_valid && instr_ready && !src && !rst) begin
      chk("sb_pc", PC, exp_pc);
      chk("sb_instr", Instr, word(exp_pc));
      chk("sb_pc4", PCPlus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (rst) exp_pc = 32'h0;
    else if (src) exp_pc = tgt & ~32'd3;
  endtask

  task automatic wait_valid(input bit rdy, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(0, 0, 32'h0, rdy, 1);
      seen = instr_valid;
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    exp_pc = 32'h0;
    mem_en = 1'b1;
    stray = 1'b0;
    reset = 1'b1;
    PCSrc = 1'b0;
    PCTarget = 32'h0;
    instr_ready = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;

    // 1: reset state, first fetches and latency
    cyc(1, 0, 32'h0, 1, 1);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_pc", PC, 32'h0);
    cyc(1, 0, 32'h0, 1, 1);
    cyc(0, 0, 32'h0, 1, 1);
    chk("c0_req", {31'b0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 32'h0, 1, 1);
    chk("c1_addr", imem_addr, 32'h4);
    chk("c1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 32'h0, 1, 1);
    chk("c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("c2_pc", PC, 32'h0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 32'h0, 1, 1);

    // 2: decode stalls, buffer fills, fetch throttles
    for (int i = 0; i < 10; i++) cyc(0, 0, 32'h0, 0, 1);
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_pend", pend.size(), 32'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 32'h0, 1, 1);

    // 3: redirect with two requests in flight
    mem_en = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 1, 1);
    chk("inflight", pend.size(), 32'd2);
    chk("inflight_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 1, 32'h100, 1, 1);
    chk("redir_req", {31'b0, imem_req}, 32'd0);
    mem_en = 1'b1;
    wait_valid(1, "redir_seen");
    chk("redir_pc", PC, 32'h100);
    chk("redir_instr", Instr, word(32'h100));
    for (int i = 0; i < 6; i++) cyc(0, 0, 32'h0, 1, 1);

    // 4: misaligned target is forced to a word address
    cyc(0, 1, 32'h103, 1, 1);
    wait_valid(1, "align_seen");
    chk("align_pc", PC, 32'h100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1, 1);

    // 5: fetch PC wraps past the top of the address space
    cyc(0, 1, 32'hFFFF_FFFC, 1, 1);
    wait_valid(1, "wrap_seen");
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4, 32'h0);
    wait_valid(1, "wrap2_seen");
    chk("wrap2_pc", PC, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1, 1);

    // 6: reset with a full buffer, stray responses around reset
    for (int i = 0; i < 6; i++) cyc(0, 0, 32'h0, 0, 1);
    chk("full_valid", {31'b0, instr_valid}, 32'd1);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    stray = 1'b1;
    cyc(1, 0, 32'h0, 1, 1);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_instr", Instr, 32'h0000_0013);
    chk("mid_rst_pc", PC, 32'h0);
    cyc(1, 0, 32'h0, 1, 1);
    stray = 1'b1;
    cyc(0, 0, 32'h0, 1, 1);
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    wait_valid(1, "post_rst_seen");
    chk("post_rst_pc", PC, 32'h0);
    chk("post_rst_instr", Instr, word(32'h0));
    for (int i = 0; i < 6; i++) cyc(0, 0, 32'h0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
